ula_muldiv: RTL and testbench

Iterative multiply/divide unit for the execute stage, operating beside `ULA` on the same register-file operands. It executes MULT, MULTU, DIV and DIVU over a fixed multi-cycle sequence and holds the 64-bit result in architectural HI/LO registers. HI and LO are read by MFHI/MFLO and written by MTHI/MTLO. The control unit stalls the pipeline while `busy` is high.

---
 rtl/ula_muldiv_pkg.sv | 28 ++
 rtl/ula_muldiv_step.sv | 42 ++++
 rtl/ula_muldiv.sv | 157 +++++++++++++++
 tb/tb_ula_muldiv.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ula_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op codes, FSM states and the iteration count.
package ula_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  localparam int MD_ITER = 32;

  function automatic logic mdIsSigned(input md_op_e opCode);
    return (opCode == MD_MULT) || (opCode == MD_DIV);
  endfunction

  function automatic logic mdIsDiv(input md_op_e opCode);
    return (opCode == MD_DIV) || (opCode == MD_DIVU);
  endfunction

endpackage

// File: rtl/ula_muldiv_step.sv
// One radix-2 iteration: shift-add multiply on {partial, multiplier}, or a
// restoring divide step on {remainder, dividend/quotient}.
module ula_muldiv_step
  import ula_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_isDiv,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_divShift;
  logic             w_divFits;
  logic [WIDTH-1:0] w_divRem;

  assign w_mulSum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
  assign w_divShift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
  assign w_divFits  = (w_divShift >= {1'b0, i_operand});
  // The true difference is below the divisor, so modulo-WIDTH subtraction is exact.
  assign w_divRem   = w_divShift[WIDTH-1:0] - i_operand;

  always_comb begin
    o_acc = '0;
    if (i_isDiv) begin
      if (w_divFits) begin
        o_acc = {w_divRem, i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {w_divShift[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (i_acc[0]) begin
        o_acc = {w_mulSum, i_acc[WIDTH-1:1]};
      end else begin
        o_acc = {1'b0, i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/ula_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Signed ops run on magnitudes; signs are reapplied in the FIX state.
module ula_muldiv
  import ula_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  md_state_e          r_state;
  md_state_e          w_nextState;
  logic [5:0]         r_count;
  md_op_e             r_op;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_operand;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  md_op_e             w_opIn;
  logic               w_inSigned;
  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic               w_isDiv;
  logic [2*WIDTH-1:0] w_stepAcc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_resHi;
  logic [WIDTH-1:0]   w_resLo;

  assign w_opIn     = md_op_e'(op);
  assign w_inSigned = mdIsSigned(w_opIn);
  assign w_neg1     = w_inSigned & in1[WIDTH-1];
  assign w_neg2     = w_inSigned & in2[WIDTH-1];
  assign w_mag1     = w_neg1 ? (-in1) : in1;
  assign w_mag2     = w_neg2 ? (-in2) : in2;
  assign w_isDiv    = mdIsDiv(r_op);

  ula_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_isDiv  (w_isDiv),
    .i_acc    (r_acc),
    .i_operand(r_operand),
    .o_acc    (w_stepAcc)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      MD_IDLE: if (start) w_nextState = MD_CALC;
      MD_CALC: if (r_count == 6'(MD_ITER - 1)) w_nextState = MD_FIX;
      MD_FIX:  w_nextState = MD_IDLE;
      default: w_nextState = MD_IDLE;
    endcase
  end

  // Divide by zero bypasses the datapath result but still takes the full latency.
  assign w_prod = r_negRes ? (-r_acc) : r_acc;
  assign w_quot = r_acc[WIDTH-1:0];
  assign w_rem  = r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_resHi = w_prod[2*WIDTH-1:WIDTH];
    w_resLo = w_prod[WIDTH-1:0];
    if (w_isDiv) begin
      if (r_divZero) begin
        w_resHi = r_dividend;
        w_resLo = '1;
      end else begin
        w_resLo = r_negRes ? (-w_quot) : w_quot;
        w_resHi = r_negRem ? (-w_rem) : w_rem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_op       <= MD_MULT;
      r_dividend <= '0;
      r_operand  <= '0;
      r_acc      <= '0;
      r_negRes   <= 1'b0;
      r_negRem   <= 1'b0;
      r_divZero  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy <= (w_nextState != MD_IDLE);
      r_done <= (r_state == MD_FIX);
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            r_count    <= '0;
            r_op       <= w_opIn;
            r_dividend <= in1;
            r_operand  <= w_mag2;
            r_acc      <= {{WIDTH{1'b0}}, w_mag1};
            r_negRes   <= w_neg1 ^ w_neg2;
            r_negRem   <= w_neg1;
            r_divZero  <= (in2 == '0);
          end else begin
            if (wr_hi) r_hi <= wr_data;
            if (wr_lo) r_lo <= wr_data;
          end
        end
        MD_CALC: begin
          r_acc   <= w_stepAcc;
          r_count <= r_count + 6'd1;
        end
        MD_FIX: begin
          r_hi <= w_resHi;
          r_lo <= w_resLo;
        end
        default: ;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_ula_muldiv.sv
// Self-checking bench for ula_muldiv: directed corner cases plus randomized
// operations checked against a 64-bit arithmetic reference model.
module tb_ula_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mHi;
  logic [31:0] mLo;

  ula_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .in1    (in1),
    .in2    (in2),
    .wr_hi  (wr_hi),
    .wr_lo  (wr_lo),
    .wr_data(wr_data),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain 64-bit arithmetic; SV division truncates toward zero.
  function automatic void refModel(input logic [1:0] opV, input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl);
    longint      sa;
    longint      sb;
    longint      sp;
    longint      sq;
    longint      sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = '0;
    rl = '0;
    case (opV)
      2'b00: begin
        sp = sa * sb;
        rh = sp[63:32];
        rl = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        rh = up[63:32];
        rl = up[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          rl = sq[31:0];
          rh = sr[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one op from a negedge; ends at the negedge of cycle 34 so a following
  // call is a back-to-back start. Cycle arguments of 0 disable the injection.
  task automatic applyStimulus(input string tag, input logic [1:0] opV,
                               input logic [31:0] a, input logic [31:0] b,
                               input int startPulseCyc, input int wrHiCyc,
                               input int resetCyc, input bit wrLoWithStart);
    logic [31:0] eHi;
    logic [31:0] eLo;
    refModel(opV, a, b, eHi, eLo);
    op      = opV;
    in1     = a;
    in2     = b;
    start   = 1'b1;
    wr_lo   = wrLoWithStart;
    wr_data = 32'h0000_1234;
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      start = 1'b0;
      wr_hi = 1'b0;
      wr_lo = 1'b0;
      reset = 1'b0;
      op    = 2'($urandom);
      in1   = $urandom;
      in2   = $urandom;
      if (resetCyc > 0 && n > resetCyc) begin
        checkOutput({tag, "_rst_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_rst_done"}, 32'(done), 32'd0);
        if (n == resetCyc + 1) begin
          checkOutput({tag, "_rst_hi"}, hi, 32'd0);
          checkOutput({tag, "_rst_lo"}, lo, 32'd0);
        end
      end else begin
        checkOutput({tag, "_busy"}, 32'(busy), 32'(n <= 33));
        checkOutput({tag, "_done"}, 32'(done), 32'(n == 34));
        if (n == 34) begin
          checkOutput({tag, "_hi"}, hi, eHi);
          checkOutput({tag, "_lo"}, lo, eLo);
        end else if (n == 1 || n == 17 || n == 33) begin
          checkOutput({tag, "_hold_hi"}, hi, mHi);
          checkOutput({tag, "_hold_lo"}, lo, mLo);
        end
      end
      if (n == startPulseCyc) start = 1'b1;
      if (n == wrHiCyc) begin
        wr_hi   = 1'b1;
        wr_data = 32'hDEAD_BEEF;
      end
      if (n == resetCyc) reset = 1'b1;
    end
    if (resetCyc > 0) begin
      mHi = '0;
      mLo = '0;
    end else begin
      mHi = eHi;
      mLo = eLo;
    end
  endtask

  task automatic mtWrite(input string tag, input bit wh, input bit wl, input logic [31:0] data);
    wr_hi   = wh;
    wr_lo   = wl;
    wr_data = data;
    start   = 1'b0;
    @(negedge clk);
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    if (wh) mHi = data;
    if (wl) mLo = data;
    checkOutput({tag, "_hi"}, hi, mHi);
    checkOutput({tag, "_lo"}, lo, mLo);
  endtask

  initial begin
    logic [1:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    in1     = '0;
    in2     = '0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    wr_data = '0;
    mHi     = '0;
    mLo     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    mtWrite("mt_both", 1'b1, 1'b1, 32'hA5A5_0001);
    mtWrite("mt_hi", 1'b1, 1'b0, 32'h1111_2222);
    mtWrite("mt_lo", 1'b0, 1'b1, 32'h3333_4444);

    applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1'b0);
    checkOutput("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    checkOutput("multu_max_lo_const", lo, 32'h0000_0001);
    applyStimulus("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 1'b0);
    checkOutput("mult_neg3x5_lo_const", lo, 32'hFFFF_FFF1);
    applyStimulus("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 1'b0);
    applyStimulus("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 1'b0);
    applyStimulus("divu_7_2", 2'b11, 32'd7, 32'd2, 0, 0, 0, 1'b0);
    applyStimulus("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, 1'b0);
    checkOutput("div_7_neg2_hi_const", hi, 32'd1);
    applyStimulus("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 1'b0);
    checkOutput("div_ovf_lo_const", lo, 32'h8000_0000);
    applyStimulus("divu_by0", 2'b11, 32'd5, 32'd0, 0, 0, 0, 1'b0);
    applyStimulus("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'd0, 0, 0, 0, 1'b0);
    applyStimulus("start_ignored", 2'b01, 32'd123456, 32'd789, 10, 0, 0, 1'b0);
    applyStimulus("wrhi_busy", 2'b10, 32'd1000, 32'd7, 0, 5, 0, 1'b0);
    applyStimulus("start_wins", 2'b11, 32'd100, 32'd7, 0, 0, 0, 1'b1);
    applyStimulus("reset_mid", 2'b00, 32'd77, 32'd99, 0, 0, 12, 1'b0);
    applyStimulus("after_reset", 2'b00, 32'hFFFF_FFF0, 32'd16, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      rOp = 2'($urandom);
      rA  = $urandom;
      case ($urandom_range(0, 5))
        0:       rB = 32'd0;
        1:       rB = $urandom_range(1, 15);
        2:       rB = -($urandom_range(1, 15));
        default: rB = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) rA = $urandom_range(0, 1000);
      applyStimulus($sformatf("rand%0d", i), rOp, rA, rB, 0, 0, 0, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        mtWrite($sformatf("rand_mt%0d", i), 1'(($urandom)), 1'(($urandom)), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
